// File: rtl/riscv_pkg.sv
// Shared integer-pipeline definitions: default widths, load funct3 encodings,
// writeback source select and the load extension helper.
package riscv_pkg;

  localparam int ADDRSIZE_DEF = 5;
  localparam int WORDSIZE_DEF = 64;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_PIPE,
    SEL_QUEUE,
    SEL_DIRECT
  } wb_sel_e;

  // Unlisted encodings (111) behave as LD and pass the word through.
  function automatic logic [WORDSIZE_DEF-1:0] ld_extend(
    input logic [WORDSIZE_DEF-1:0] data,
    input logic [2:0]              funct3
  );
    logic [WORDSIZE_DEF-1:0] r;
    case (funct3)
      F3_LB:   r = {{(WORDSIZE_DEF-8){data[7]}}, data[7:0]};
      F3_LH:   r = {{(WORDSIZE_DEF-16){data[15]}}, data[15:0]};
      F3_LW:   r = {{(WORDSIZE_DEF-32){data[31]}}, data[31:0]};
      F3_LBU:  r = {{(WORDSIZE_DEF-8){1'b0}}, data[7:0]};
      F3_LHU:  r = {{(WORDSIZE_DEF-16){1'b0}}, data[15:0]};
      F3_LWU:  r = {{(WORDSIZE_DEF-32){1'b0}}, data[31:0]};
      F3_LD:   r = data;
      default: r = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// Writeback bus: pipeline result channel, long-latency valid/ready channel and
// the register file write port. The writeback stage is the slave.
interface writeback_stage_if
  import riscv_pkg::*;
#(
  parameter int ADDRSIZE = ADDRSIZE_DEF,
  parameter int WORDSIZE = WORDSIZE_DEF
);
  logic                p_valid;
  logic                p_regwr;
  logic [ADDRSIZE-1:0] p_rd;
  logic [WORDSIZE-1:0] p_data;
  logic                p_ld;
  logic [2:0]          p_funct3;

  logic                l_valid;
  logic                l_ready;
  logic [ADDRSIZE-1:0] l_rd;
  logic [WORDSIZE-1:0] l_data;

  logic                regwr;
  logic [ADDRSIZE-1:0] rd;
  logic [WORDSIZE-1:0] rddata;

  modport master (
    output p_valid, p_regwr, p_rd, p_data, p_ld, p_funct3,
    output l_valid, l_rd, l_data,
    input  l_ready,
    input  regwr, rd, rddata
  );

  modport slave (
    input  p_valid, p_regwr, p_rd, p_data, p_ld, p_funct3,
    input  l_valid, l_rd, l_data,
    output l_ready,
    output regwr, rd, rddata
  );
endinterface

// File: rtl/wb_lq_fifo.sv
// Small FIFO buffering long-latency results until the pipeline channel leaves
// a free writeback slot. DEPTH must be a power of two.
module wb_lq_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = ADDRSIZE_DEF + WORDSIZE_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o,
  output logic                   full_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & ~full_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage driving the register file write port from the pipeline
// and long-latency channels. Define WB_FWD_EN to add write-to-read bypass ports.
module writeback_stage
  import riscv_pkg::*;
#(
  parameter int ADDRSIZE = ADDRSIZE_DEF,
  parameter int WORDSIZE = WORDSIZE_DEF,
  parameter int LQDEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  writeback_stage_if.slave         bus,
  output logic [$clog2(LQDEPTH):0] lq_count
`ifdef WB_FWD_EN
  ,
  input  logic [ADDRSIZE-1:0]      rs1,
  input  logic [ADDRSIZE-1:0]      rs2,
  input  logic [WORDSIZE-1:0]      rf_rs1data,
  input  logic [WORDSIZE-1:0]      rf_rs2data,
  output logic [WORDSIZE-1:0]      rs1data,
  output logic [WORDSIZE-1:0]      rs2data
`endif
);
  localparam int EW = ADDRSIZE + WORDSIZE;

  logic                p_win;
  logic                l_fire;
  logic                lq_empty, lq_full;
  logic                lq_push, lq_pop;
  logic [EW-1:0]       lq_head;
  logic [ADDRSIZE-1:0] head_rd;
  logic [WORDSIZE-1:0] head_data;
  wb_sel_e             sel;

  logic                regwr_d, regwr_q;
  logic [ADDRSIZE-1:0] rd_d, rd_q;
  logic [WORDSIZE-1:0] rddata_d, rddata_q;

  assign p_win = bus.p_valid & bus.p_regwr & (bus.p_rd != '0);

  // Ready looks only at registered occupancy, so a full queue refuses even when popping.
  assign bus.l_ready = ~rst & ~lq_full;
  assign l_fire      = bus.l_valid & bus.l_ready;

  assign head_rd   = lq_head[EW-1:WORDSIZE];
  assign head_data = lq_head[WORDSIZE-1:0];

  always_comb begin
    sel = SEL_NONE;
    if (p_win)          sel = SEL_PIPE;
    else if (!lq_empty) sel = SEL_QUEUE;
    else if (l_fire)    sel = SEL_DIRECT;
  end

  assign lq_pop  = (sel == SEL_QUEUE);
  assign lq_push = l_fire & (sel != SEL_DIRECT);

  wb_lq_fifo #(
    .DEPTH (LQDEPTH),
    .WIDTH (EW)
  ) u_lq (
    .clk         (clk),
    .rst         (rst),
    .push_i      (lq_push),
    .push_data_i ({bus.l_rd, bus.l_data}),
    .pop_i       (lq_pop),
    .head_o      (lq_head),
    .count_o     (lq_count),
    .empty_o     (lq_empty),
    .full_o      (lq_full)
  );

  // Long-latency beats to x0 are consumed silently; rd/rddata hold whenever no write.
  always_comb begin
    regwr_d  = 1'b0;
    rd_d     = rd_q;
    rddata_d = rddata_q;
    case (sel)
      SEL_PIPE: begin
        regwr_d  = 1'b1;
        rd_d     = bus.p_rd;
        rddata_d = bus.p_ld ? ld_extend(bus.p_data, bus.p_funct3) : bus.p_data;
      end
      SEL_QUEUE: begin
        if (head_rd != '0) begin
          regwr_d  = 1'b1;
          rd_d     = head_rd;
          rddata_d = head_data;
        end
      end
      SEL_DIRECT: begin
        if (bus.l_rd != '0) begin
          regwr_d  = 1'b1;
          rd_d     = bus.l_rd;
          rddata_d = bus.l_data;
        end
      end
      default: regwr_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regwr_q  <= 1'b0;
      rd_q     <= '0;
      rddata_q <= '0;
    end else begin
      regwr_q  <= regwr_d;
      rd_q     <= rd_d;
      rddata_q <= rddata_d;
    end
  end

  assign bus.regwr  = regwr_q;
  assign bus.rd     = rd_q;
  assign bus.rddata = rddata_q;

`ifdef WB_FWD_EN
  assign rs1data = (regwr_q && (rd_q == rs1) && (rs1 != '0)) ? rddata_q : rf_rs1data;
  assign rs2data = (regwr_q && (rd_q == rs2) && (rs2 != '0)) ? rddata_q : rf_rs2data;
`endif

endmodule
